// File: rtl/bin_serializer.sv
// Parallel-to-serial feeder for the double-dabble display chain: saturates the
// accepted value to MAX and shifts it out MSB-first between a clr and a done strobe.
module bin_serializer #(
  parameter int WIDTH = 10,
  parameter int MAX   = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             din,
  output logic             shift_en,
  output logic             clr,
  output logic             done,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MAX);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  // Outputs are registered alongside the state, so each is driven from the
  // transition into the state where it must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      ready    <= 1'b1;
      din      <= 1'b0;
      shift_en <= 1'b0;
      clr      <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && ready) begin
            sreg  <= (data > MAXV) ? MAXV : data;
            ovf   <= (data > MAXV);
            ready <= 1'b0;
            clr   <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          clr      <= 1'b0;
          cnt      <= CNT_LOAD;
          shift_en <= 1'b1;
          din      <= sreg[WIDTH-1];
          sreg     <= sreg << 1;
          state    <= SHIFT;
        end
        SHIFT: begin
          // The first bit already went out on entry, so cnt==0 marks the last one.
          if (cnt == '0) begin
            shift_en <= 1'b0;
            din      <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt  <= cnt - CW'(1);
            din  <= sreg[WIDTH-1];
            sreg <= sreg << 1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_serializer.sv
// Self-checking bench for bin_serializer: directed and random conversions checked
// against an arithmetic model of the serial stream and a value-accumulating chain model.
module tb_bin_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] data;
  logic       valid;
  logic       ready, din, shift_en, clr, done, ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int chain     = 0;
  int shiftCnt  = 0;
  bit clrSeen   = 0;
  int doneCount = 0;
  int acc[$];

  bin_serializer #(.WIDTH(10), .MAX(999)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
    .din(din), .shift_en(shift_en), .clr(clr), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] d, input logic v);
    data  = d;
    valid = v;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Downstream chain modelled as a plain number: clr zeroes it, each shift
  // appends din as the new LSB.
  always @(negedge clk) begin
    if (rst) begin
      shiftCnt = 0;
      clrSeen  = 0;
    end else begin
      checkOutput("onehot", 32'(int'(clr) + int'(shift_en) + int'(done) <= 1), 1);
      if (!shift_en) checkOutput("din_quiet", din, 0);
      if (ready && valid) acc.push_back(cyc);
      if (clr) begin
        chain    = 0;
        shiftCnt = 0;
        clrSeen  = 1;
      end
      if (shift_en) begin
        chain = chain * 2 + int'(din);
        shiftCnt++;
      end
      if (done) begin
        checkOutput("shift_count", shiftCnt, 10);
        checkOutput("clr_before_done", clrSeen, 1);
        doneCount++;
        shiftCnt = 0;
        clrSeen  = 0;
      end
    end
  end

  // Called in an IDLE cycle (ready expected high); returns in the cycle ready is back.
  task automatic runConversion(input logic [9:0] value, input bit disturb);
    logic [9:0] satv;
    bit expOvf;
    expOvf = (value > 10'd999);
    satv   = expOvf ? 10'd999 : value;
    checkOutput("ready_c0", ready, 1);
    applyStimulus(value, 1'b1);
    nextCycle();
    applyStimulus(10'($urandom_range(0, 1023)), 1'b0);
    checkOutput("clr_c1", clr, 1);
    checkOutput("ready_c1", ready, 0);
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      checkOutput("shift_en", shift_en, 1);
      checkOutput($sformatf("din_bit%0d", 9 - i), din, satv[9-i]);
      checkOutput("ready_shift", ready, 0);
      if (disturb && i == 3) applyStimulus(~value, 1'b1);
      if (disturb && i == 6) applyStimulus(10'($urandom_range(0, 1023)), 1'b0);
    end
    nextCycle();
    checkOutput("done_c12", done, 1);
    checkOutput("ready_c12", ready, 0);
    checkOutput("ovf", ovf, expOvf);
    checkOutput("chain_hund", chain / 100, satv / 100);
    checkOutput("chain_tens", (chain / 10) % 10, (satv / 10) % 10);
    checkOutput("chain_ones", chain % 10, satv % 10);
    nextCycle();
    checkOutput("ready_c13", ready, 1);
    checkOutput("done_c13", done, 0);
    checkOutput("ovf_hold", ovf, expOvf);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSnap;
    rst = 1'b1;
    applyStimulus(10'd0, 1'b0);
    repeat (3) nextCycle();
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_din", din, 0);
    checkOutput("rst_shift_en", shift_en, 0);
    checkOutput("rst_clr", clr, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovf", ovf, 0);
    rst = 1'b0;
    nextCycle();

    runConversion(10'd255, 1'b0);
    checkOutput("d255_hund", chain / 100, 2);
    checkOutput("d255_tens", (chain / 10) % 10, 5);
    checkOutput("d255_ones", chain % 10, 5);
    runConversion(10'd1000, 1'b0);
    runConversion(10'd1023, 1'b0);
    checkOutput("sat_chain", chain, 999);
    runConversion(10'd0, 1'b0);
    checkOutput("zero_chain", chain, 0);

    // Valid held high across two conversions.
    acc.delete();
    applyStimulus(10'd999, 1'b1);
    nextCycle();
    applyStimulus(10'd1, 1'b1);
    checkOutput("held_clr1", clr, 1);
    repeat (11) nextCycle();
    checkOutput("held_done1", done, 1);
    checkOutput("held_chain1", chain, 999);
    nextCycle();
    checkOutput("held_ready", ready, 1);
    nextCycle();
    applyStimulus(10'd1, 1'b0);
    checkOutput("held_clr2", clr, 1);
    repeat (11) nextCycle();
    checkOutput("held_done2", done, 1);
    checkOutput("held_chain2", chain, 1);
    checkOutput("held_ovf2", ovf, 0);
    nextCycle();
    checkOutput("held_accepts", acc.size(), 2);
    if (acc.size() >= 2) checkOutput("held_spacing", acc[1] - acc[0], 13);

    // Reset during the shift of 512.
    doneSnap = doneCount;
    applyStimulus(10'd512, 1'b1);
    nextCycle();
    applyStimulus(10'd512, 1'b0);
    repeat (5) nextCycle();
    rst = 1'b1;
    nextCycle();
    checkOutput("abort_ready", ready, 1);
    checkOutput("abort_shift_en", shift_en, 0);
    checkOutput("abort_din", din, 0);
    checkOutput("abort_clr", clr, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_ovf", ovf, 0);
    // rst and valid together: nothing accepted.
    applyStimulus(10'd7, 1'b1);
    nextCycle();
    rst = 1'b0;
    applyStimulus(10'd7, 1'b0);
    checkOutput("rstvalid_clr", clr, 0);
    checkOutput("rstvalid_ready", ready, 1);
    repeat (14) nextCycle();
    checkOutput("abort_no_done", doneCount, doneSnap);
    runConversion(10'd42, 1'b0);
    checkOutput("d42_chain", chain, 42);

    runConversion(10'd613, 1'b1);
    for (int k = 0; k < 8; k++) begin
      runConversion(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_serializer.md
# bin_serializer

Upstream feeder for the three-digit double-dabble display chain. It accepts a parallel binary value over a valid/ready handshake, saturates it to the displayable range, and drives the chain's serial input MSB-first, one bit per enabled cycle. Around each conversion it also generates the chain's clear and shift-enable controls and a completion strobe, so downstream digit registers hold a stable BCD result between conversions.

## Interface
- WIDTH, 10: binary input width; also the number of shift cycles per conversion.
- MAX, 999: largest displayable value; larger inputs saturate to MAX.

- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- data  in  WIDTH  unsigned binary value to convert.
- valid  in  1  data is valid this cycle.
- ready  out  1  block can accept data this cycle.
- din  out  1  serial bit to the dabble chain, MSB first.
- shift_en  out  1  chain shifts in din this cycle.
- clr  out  1  one-cycle clear of all chain digit registers.
- done  out  1  one-cycle strobe: chain now holds the final BCD result.
- ovf  out  1  last accepted value exceeded MAX and was saturated.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DONE.
- IDLE: ready=1. On valid&&ready, capture sat = (data>MAX) ? MAX : data into the WIDTH-bit shift register. Set ovf = (data>MAX). Go to CLEAR.
- CLEAR: clr=1 for exactly one cycle. Load bit counter with WIDTH-1. Go to SHIFT.
- SHIFT: shift_en=1. din = shift register MSB. Shift the register left by one and fill with 0. Decrement the counter. When the counter is 0 in this state, go to DONE after this cycle. SHIFT lasts exactly WIDTH cycles.
- DONE: done=1 for one cycle. Go to IDLE.
- valid outside IDLE is ignored. data is sampled only on the accept edge, so later changes to data have no effect.
- ovf holds its value until the next accept.
- din=0 whenever shift_en=0.
- Comparison data>MAX is unsigned at WIDTH bits. MAX must fit in WIDTH bits.

## Timing
- All outputs are registered.
- Reset values: ready=1, din=0, shift_en=0, clr=0, done=0, ovf=0. State=IDLE, shift register=0, counter=0.
- Accept edge = cycle 0. Then:
  - clr high in cycle 1.
  - shift_en high in cycles 2..WIDTH+1, with din = bit WIDTH-1 down to bit 0.
  - done high in cycle WIDTH+2.
  - ready high again in cycle WIDTH+3.
  - For WIDTH=10: shifting occupies cycles 2..11, done is in cycle 12, ready returns in cycle 13.
- Throughput: one conversion per WIDTH+3 cycles. With valid held high, the next accept happens on the first IDLE cycle.
- ready is low from cycle 1 through cycle WIDTH+2 inclusive.
- Reset mid-operation (any state): on the next edge, return to IDLE with all outputs at reset values. No done is issued for the aborted conversion. Downstream contents are undefined until the next conversion's clr.
- rst and valid asserted in the same cycle: rst wins and nothing is accepted.
- clr, shift_en and done are mutually exclusive in every cycle.

## Test plan
- Reset, then data=255 with a single-cycle valid. Required:
  - clr in cycle 1.
  - din sequence 0,0,1,1,1,1,1,1,1,1 over cycles 2..11.
  - done in cycle 12, ovf=0, ready in cycle 13.
  - Downstream chain model shows digits 2,5,5.
- data=1000, then separately data=1023. Each must serialize as 999 (1111100111) with ovf=1. Next data=0 must serialize as ten 0s with ovf=0, and the chain must read 0,0,0.
- valid held high with data=999 and then 1. Required:
  - Accepts 13 cycles apart.
  - Each conversion preceded by its own clr.
  - Chain reads 9,9,9 at the first done and 0,0,1 at the second.
- rst asserted in cycle 6 of a conversion of 512. Required:
  - The next cycle shows all outputs at reset values and ready=1.
  - No done is issued.
  - A following conversion of 42 completes normally and the chain reads 0,4,2.
- Change data and pulse valid during SHIFT. Required: both are ignored, and the din sequence matches the originally accepted value exactly.
- Protocol assertions checked on every cycle:
  - shift_en count per conversion is exactly WIDTH.
  - clr, shift_en and done are one-hot or all zero.
  - din=0 whenever shift_en=0.
